// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller.
// State encoding, grant encoding and default latency.
package mem_ctrl_pkg;

    localparam int MEM_LATENCY_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_LS = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait counter for the ACCESS phase.
// Counts 0..MEM_LATENCY-1 and flags the terminal count.
module mem_wait_counter
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(MEM_LATENCY + 1);

    logic [CW-1:0] count;

    // Count while enabled; clear has priority so the counter restarts at 0
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(MEM_LATENCY - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Two-port (fetch / load-store) memory access controller.
// Round-robin on ties, fixed-latency access, one-cycle completion.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          ir_load,
    output logic          mdr_load,
    output logic          busy
);

    state_t state;
    grant_t gnt;
    grant_t last_grant;
    grant_t pick;
    logic   tc;
    logic   cnt_clear;
    logic   cnt_en;
    logic   unused_rdata;

    // Read data goes straight to the IR/MDR outside this block
    assign unused_rdata = ^mem_rdata;

    assign cnt_en    = (state == ACCESS);
    assign cnt_clear = (state != ACCESS) || tc;

    mem_wait_counter #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_wait (
        .clk  (clk),
        .reset(reset),
        .clear(cnt_clear),
        .en   (cnt_en),
        .tc   (tc)
    );

    // Lone requester wins; on a tie the one not granted last wins
    always_comb begin
        pick = GNT_IF;
        if (ls_req && (!if_req || last_grant == GNT_IF)) begin
            pick = GNT_LS;
        end
    end

    // Controller FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= GNT_IF;
            last_grant <= GNT_LS;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            ls_ack     <= 1'b0;
            ir_load    <= 1'b0;
            mdr_load   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if_ack   <= 1'b0;
            ls_ack   <= 1'b0;
            ir_load  <= 1'b0;
            mdr_load <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (if_req || ls_req) begin
                        state      <= ACCESS;
                        gnt        <= pick;
                        last_grant <= pick;
                        mem_en     <= 1'b1;
                        busy       <= 1'b1;
                        if (pick == GNT_LS) begin
                            mem_we    <= ls_we;
                            mem_addr  <= ls_addr;
                            mem_wdata <= ls_wdata;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= if_addr;
                        end
                    end
                end
                ACCESS: begin
                    if (tc) begin
                        state  <= DONE;
                        mem_we <= 1'b0;
                        if (gnt == GNT_IF) begin
                            if_ack  <= 1'b1;
                            ir_load <= 1'b1;
                        end else begin
                            ls_ack   <= 1'b1;
                            mdr_load <= !mem_we;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (MEM_LATENCY = 2).
// Transaction-level model plus directed literal checks.
module tb_mem_access_ctrl;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        ir_load;
    logic        mdr_load;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_access_ctrl #(
        .MEM_LATENCY(LAT),
        .AW(32),
        .DW(32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_ack   (ls_ack),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .ir_load  (ir_load),
        .mdr_load (mdr_load),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    // Transaction model: el = cycles elapsed since the grant edge, 0 = idle
    int          el = 0;
    bit          started = 0;
    bit          m_ls = 0;
    bit          m_last = 1;
    bit          m_we = 0;
    logic [31:0] m_addr = 0;
    logic [31:0] m_wdata = 0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            el      = 0;
            m_last  = 1;
            m_we    = 0;
            m_addr  = 0;
            m_wdata = 0;
            started = 1;
        end else if (el == 0) begin
            if (if_req || ls_req) begin
                m_ls   = ls_req && (!if_req || m_last == 0);
                m_last = m_ls;
                el     = 1;
                if (m_ls) begin
                    m_we    = ls_we;
                    m_addr  = ls_addr;
                    m_wdata = ls_wdata;
                end else begin
                    m_we   = 0;
                    m_addr = if_addr;
                end
            end
        end else if (el == LAT + 1) begin
            el = 0;
        end else begin
            el++;
        end
        #1;
        if (started) begin
            chk("m_en", mem_en, el != 0);
            chk("m_busy", busy, el != 0);
            chk("m_we", mem_we, m_we && el >= 1 && el <= LAT);
            chk("m_addr", mem_addr, m_addr);
            chk("m_wdata", mem_wdata, m_wdata);
            chk("m_ifack", if_ack, el == LAT + 1 && !m_ls);
            chk("m_lsack", ls_ack, el == LAT + 1 && m_ls);
            chk("m_ir", ir_load, el == LAT + 1 && !m_ls);
            chk("m_mdr", mdr_load, el == LAT + 1 && m_ls && !m_we);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    int ack_cyc[4];
    bit ack_ls[4];
    int nack;
    int waited;

    initial begin
        reset = 1; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0;
        ls_addr = 0; ls_wdata = 0; mem_rdata = 0;
        step(); step();
        chk("rst_en", mem_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", mem_addr, 0);
        reset = 0;
        step();

        // Fetch 0x40
        if_req = 1; if_addr = 32'h40;
        step();
        chk("f_c1_en", mem_en, 1);
        chk("f_c1_addr", mem_addr, 32'h40);
        step();
        chk("f_c2_ack", if_ack, 0);
        step();
        chk("f_c3_ack", if_ack, 1);
        chk("f_c3_ir", ir_load, 1);
        chk("f_c3_en", mem_en, 1);
        if_req = 0;
        step();
        chk("f_c4_en", mem_en, 0);
        chk("f_c4_busy", busy, 0);

        // Store 0xDEADBEEF to 0x100
        ls_req = 1; ls_we = 1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF;
        step();
        chk("s_c1_we", mem_we, 1);
        chk("s_c1_wd", mem_wdata, 32'hDEAD_BEEF);
        step();
        chk("s_c2_we", mem_we, 1);
        step();
        chk("s_c3_ack", ls_ack, 1);
        chk("s_c3_mdr", mdr_load, 0);
        chk("s_c3_we", mem_we, 0);
        ls_req = 0; ls_we = 0;
        step();

        // Load from 0x200
        ls_req = 1; ls_addr = 32'h200;
        step();
        step();
        mem_rdata = 32'h1234_5678;
        step();
        chk("l_c3_mdr", mdr_load, 1);
        chk("l_c3_ack", ls_ack, 1);
        chk("l_c3_ir", ir_load, 0);
        ls_req = 0;
        step();

        // Request dropped and address changed after grant
        ls_req = 1; ls_addr = 32'h300;
        step();
        ls_req = 0; ls_addr = 32'h999;
        step();
        chk("d_c2_addr", mem_addr, 32'h300);
        step();
        chk("d_c3_ack", ls_ack, 1);
        step();

        // Both requesters held high: IF first, then alternate
        nack = 0;
        if_req = 1; if_addr = 32'h500;
        ls_req = 1; ls_addr = 32'h600;
        for (int i = 0; i < 16; i++) begin
            step();
            if (if_ack && ls_ack) chk("t_both_ack", 1, 0);
            if ((if_ack || ls_ack) && nack < 4) begin
                ack_cyc[nack] = cyc;
                ack_ls[nack]  = ls_ack;
                nack++;
            end
        end
        if_req = 0; ls_req = 0;
        chk("t_nack", nack, 4);
        chk("t_k0", ack_ls[0], 0);
        chk("t_k1", ack_ls[1], 1);
        chk("t_k2", ack_ls[2], 0);
        chk("t_k3", ack_ls[3], 1);
        chk("t_sp1", ack_cyc[1] - ack_cyc[0], 4);
        chk("t_sp2", ack_cyc[2] - ack_cyc[1], 4);
        chk("t_sp3", ack_cyc[3] - ack_cyc[2], 4);
        waited = 0;
        while (busy && waited < 20) begin
            step();
            waited++;
        end
        chk("t_idle_to", waited < 20, 1);
        step();

        // Reset in cycle 2 of a load
        ls_req = 1; ls_addr = 32'h400;
        step();
        step();
        reset = 1;
        step();
        chk("r_c3_ack", ls_ack, 0);
        chk("r_c3_mdr", mdr_load, 0);
        chk("r_c3_en", mem_en, 0);
        chk("r_c3_busy", busy, 0);
        chk("r_c3_addr", mem_addr, 0);
        reset = 0; ls_req = 0;
        step();

        // Normal fetch after the abort
        if_req = 1; if_addr = 32'h80;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!if_ack && waited < 10);
        chk("p_lat", waited, 3);
        chk("p_ir", ir_load, 1);
        if_req = 0;
        step(); step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
